// File: rtl/sparce_skip_engine.sv
// SparCE skip engine: turns a SASA-table hit into a fetch redirect once the
// entry's source registers are hazard-free and the sparsity condition holds.
package sparce_skip_engine_pkg;
    typedef enum logic {SASA_COND_OR = 1'b0, SASA_COND_AND = 1'b1} sasa_cond_t;
endpackage

module sparce_skip_engine
    import sparce_skip_engine_pkg::*;
#(
    parameter int PC_WIDTH       = 32,
    parameter int HAZARD_TIMEOUT = 3,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 sasa_valid,
    input  logic [4:0]           sasa_rs1,
    input  logic [4:0]           sasa_rs2,
    input  sasa_cond_t           sasa_cond,
    input  logic [4:0]           insts_to_skip,
    input  logic [PC_WIDTH-1:0]  preceding_pc,
    input  logic [31:0]          sparsity_vec,
    input  logic [31:0]          pending_wr_vec,
    input  logic                 pipe_flush,
    input  logic                 skip_ready,
    output logic                 skip_valid,
    output logic [PC_WIDTH-1:0]  skip_target,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] skip_count,
    output logic [CNT_WIDTH-1:0] abandon_count
);

    typedef enum logic [1:0] {IDLE, EVAL, SKIP} state_t;

    state_t               state_q, state_d;
    logic [4:0]           rs1_q, rs1_d;
    logic [4:0]           rs2_q, rs2_d;
    sasa_cond_t           cond_q, cond_d;
    logic [4:0]           ninst_q, ninst_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [3:0]           wait_q, wait_d;
    logic                 skip_valid_q, skip_valid_d;
    logic [PC_WIDTH-1:0]  skip_target_q, skip_target_d;
    logic [CNT_WIDTH-1:0] skip_count_q, skip_count_d;
    logic [CNT_WIDTH-1:0] abandon_count_q, abandon_count_d;

    logic                hazard;
    logic                s1, s2;
    logic                cond_ok;
    logic [PC_WIDTH-1:0] skip_offset;

    // x0 is never written and always reads zero
    always_comb begin
        hazard  = ((rs1_q != 5'd0) && pending_wr_vec[rs1_q]) ||
                  ((rs2_q != 5'd0) && pending_wr_vec[rs2_q]);
        s1      = (rs1_q == 5'd0) || sparsity_vec[rs1_q];
        s2      = (rs2_q == 5'd0) || sparsity_vec[rs2_q];
        cond_ok = (cond_q == SASA_COND_AND) ? (s1 & s2) : (s1 | s2);
        skip_offset = PC_WIDTH'({1'b0, ninst_q} + 6'd1) << 2;
    end

    always_comb begin
        state_d         = state_q;
        rs1_d           = rs1_q;
        rs2_d           = rs2_q;
        cond_d          = cond_q;
        ninst_d         = ninst_q;
        pc_d            = pc_q;
        wait_d          = wait_q;
        skip_valid_d    = skip_valid_q;
        skip_target_d   = skip_target_q;
        skip_count_d    = skip_count_q;
        abandon_count_d = abandon_count_q;

        if (pipe_flush) begin
            state_d      = IDLE;
            skip_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sasa_valid) begin
                        rs1_d   = sasa_rs1;
                        rs2_d   = sasa_rs2;
                        cond_d  = sasa_cond;
                        ninst_d = insts_to_skip;
                        pc_d    = preceding_pc;
                        wait_d  = 4'd0;
                        state_d = EVAL;
                    end
                end
                EVAL: begin
                    if (hazard) begin
                        wait_d = wait_q + 4'd1;
                        if (wait_d == 4'(HAZARD_TIMEOUT)) begin
                            state_d = IDLE;
                            if (abandon_count_q != '1)
                                abandon_count_d = abandon_count_q + 1'b1;
                        end
                    end else if (cond_ok && (ninst_q != 5'd0)) begin
                        skip_target_d = pc_q + skip_offset;
                        skip_valid_d  = 1'b1;
                        state_d       = SKIP;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SKIP: begin
                    if (skip_ready) begin
                        skip_valid_d = 1'b0;
                        state_d      = IDLE;
                        if (skip_count_q != '1)
                            skip_count_d = skip_count_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q         <= IDLE;
            rs1_q           <= '0;
            rs2_q           <= '0;
            cond_q          <= SASA_COND_OR;
            ninst_q         <= '0;
            pc_q            <= '0;
            wait_q          <= '0;
            skip_valid_q    <= 1'b0;
            skip_target_q   <= '0;
            skip_count_q    <= '0;
            abandon_count_q <= '0;
        end else begin
            state_q         <= state_d;
            rs1_q           <= rs1_d;
            rs2_q           <= rs2_d;
            cond_q          <= cond_d;
            ninst_q         <= ninst_d;
            pc_q            <= pc_d;
            wait_q          <= wait_d;
            skip_valid_q    <= skip_valid_d;
            skip_target_q   <= skip_target_d;
            skip_count_q    <= skip_count_d;
            abandon_count_q <= abandon_count_d;
        end
    end

    assign skip_valid    = skip_valid_q;
    assign skip_target   = skip_target_q;
    assign busy          = (state_q != IDLE);
    assign skip_count    = skip_count_q;
    assign abandon_count = abandon_count_q;

endmodule

// File: tb/tb_sparce_skip_engine.sv
// Directed bench for sparce_skip_engine; a second narrow-counter instance
// shares all inputs so counter saturation is reachable in few cycles.
module tb_sparce_skip_engine;
    import sparce_skip_engine_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        sasa_valid = 1'b0;
    logic [4:0]  sasa_rs1 = '0, sasa_rs2 = '0, insts_to_skip = '0;
    sasa_cond_t  sasa_cond = SASA_COND_OR;
    logic [31:0] preceding_pc = '0, sparsity_vec = '0, pending_wr_vec = '0;
    logic        pipe_flush = 1'b0, skip_ready = 1'b0;

    logic        skip_valid, busy, skip_valid_n, busy_n;
    logic [31:0] skip_target, skip_target_n;
    logic [15:0] skip_count, abandon_count;
    logic [3:0]  skip_count_n, abandon_count_n;

    int n_cmp = 0;
    int n_bad = 0;
    int sc = 0;
    int ac = 0;

    always #5 CLK = ~CLK;

    sparce_skip_engine dut (
        .CLK(CLK), .nRST(nRST), .sasa_valid(sasa_valid), .sasa_rs1(sasa_rs1),
        .sasa_rs2(sasa_rs2), .sasa_cond(sasa_cond), .insts_to_skip(insts_to_skip),
        .preceding_pc(preceding_pc), .sparsity_vec(sparsity_vec),
        .pending_wr_vec(pending_wr_vec), .pipe_flush(pipe_flush), .skip_ready(skip_ready),
        .skip_valid(skip_valid), .skip_target(skip_target), .busy(busy),
        .skip_count(skip_count), .abandon_count(abandon_count)
    );

    sparce_skip_engine #(.CNT_WIDTH(4)) dut_n (
        .CLK(CLK), .nRST(nRST), .sasa_valid(sasa_valid), .sasa_rs1(sasa_rs1),
        .sasa_rs2(sasa_rs2), .sasa_cond(sasa_cond), .insts_to_skip(insts_to_skip),
        .preceding_pc(preceding_pc), .sparsity_vec(sparsity_vec),
        .pending_wr_vec(pending_wr_vec), .pipe_flush(pipe_flush), .skip_ready(skip_ready),
        .skip_valid(skip_valid_n), .skip_target(skip_target_n), .busy(busy_n),
        .skip_count(skip_count_n), .abandon_count(abandon_count_n)
    );

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        sasa_cond_t  cond;
        logic [4:0]  n;
        logic [31:0] pc;
        logic [31:0] spars;
        logic        exp_skip;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_counts(input string name);
        chk({name, " skip_count"}, 32'(skip_count), 32'(sc));
        chk({name, " abandon_count"}, 32'(abandon_count), 32'(ac));
        chk({name, " skip_count_sat"}, 32'(skip_count_n), 32'((sc > 15) ? 15 : sc));
    endtask

    task automatic hit(input logic [4:0] rs1, input logic [4:0] rs2, input sasa_cond_t c,
                       input logic [4:0] n, input logic [31:0] pc);
        sasa_valid = 1'b1; sasa_rs1 = rs1; sasa_rs2 = rs2; sasa_cond = c;
        insts_to_skip = n; preceding_pc = pc;
        step();
        sasa_valid = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        pending_wr_vec = '0; sparsity_vec = v.spars; skip_ready = 1'b1;
        hit(v.rs1, v.rs2, v.cond, v.n, v.pc);
        chk({name, " busy@T+1"}, 32'(busy), 32'd1);
        chk({name, " valid@T+1"}, 32'(skip_valid), 32'd0);
        step();
        chk({name, " valid@T+2"}, 32'(skip_valid), 32'(v.exp_skip));
        chk({name, " busy@T+2"}, 32'(busy), 32'(v.exp_skip));
        if (v.exp_skip) begin
            chk({name, " target"}, skip_target, v.exp_target);
            sc++;
        end
        step();
        chk({name, " idle@T+3"}, 32'(busy), 32'd0);
        chk({name, " valid@T+3"}, 32'(skip_valid), 32'd0);
        chk_counts(name);
    endtask

    initial begin
        vecs[0] = '{5'd5, 5'd6,  SASA_COND_OR,  5'd3,  32'h100,      32'h20,  1'b1, 32'h110};
        vecs[1] = '{5'd5, 5'd6,  SASA_COND_AND, 5'd3,  32'h100,      32'h20,  1'b0, 32'h0};
        vecs[2] = '{5'd5, 5'd0,  SASA_COND_AND, 5'd3,  32'h100,      32'h20,  1'b1, 32'h110};
        vecs[3] = '{5'd5, 5'd6,  SASA_COND_OR,  5'd0,  32'h100,      32'h20,  1'b0, 32'h0};
        vecs[4] = '{5'd5, 5'd6,  SASA_COND_OR,  5'd1,  32'hFFFFFFF8, 32'h20,  1'b1, 32'h0};
        vecs[5] = '{5'd5, 5'd6,  SASA_COND_OR,  5'd3,  32'h100,      32'h0,   1'b0, 32'h0};
        vecs[6] = '{5'd7, 5'd9,  SASA_COND_AND, 5'd31, 32'h2000,     32'h280, 1'b1, 32'h2080};
        vecs[7] = '{5'd0, 5'd10, SASA_COND_OR,  5'd2,  32'h40,       32'h0,   1'b1, 32'h4C};

        step(); step();
        chk("rst skip_valid", 32'(skip_valid), 32'd0);
        chk("rst skip_target", skip_target, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk_counts("rst");
        @(negedge CLK);
        nRST = 1'b1;
        step();

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // hazard on rs1 for two EVAL cycles then clear: redirect at T+4
        sparsity_vec = 32'h20; skip_ready = 1'b1; pending_wr_vec = 32'h20;
        hit(5'd5, 5'd6, SASA_COND_OR, 5'd3, 32'h100);
        step();
        chk("haz2 valid@T+2", 32'(skip_valid), 32'd0);
        chk("haz2 busy@T+2", 32'(busy), 32'd1);
        step();
        chk("haz2 valid@T+3", 32'(skip_valid), 32'd0);
        pending_wr_vec = '0;
        step();
        chk("haz2 valid@T+4", 32'(skip_valid), 32'd1);
        chk("haz2 target", skip_target, 32'h110);
        sc++;
        step();
        chk("haz2 idle", 32'(busy), 32'd0);
        chk_counts("haz2");

        // hazard held through the timeout: abandon with no redirect
        pending_wr_vec = 32'h40;
        hit(5'd5, 5'd6, SASA_COND_OR, 5'd3, 32'h100);
        step(); step();
        chk("haz3 busy@T+3", 32'(busy), 32'd1);
        step();
        ac++;
        chk("haz3 idle@T+4", 32'(busy), 32'd0);
        chk("haz3 valid@T+4", 32'(skip_valid), 32'd0);
        chk_counts("haz3");
        pending_wr_vec = '0;

        // backpressure then flush racing ready
        skip_ready = 1'b0;
        hit(5'd5, 5'd6, SASA_COND_OR, 5'd4, 32'h300);
        step();
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("bp valid c%0d", k), 32'(skip_valid), 32'd1);
            chk($sformatf("bp target c%0d", k), skip_target, 32'h314);
        end
        pipe_flush = 1'b1; skip_ready = 1'b1;
        step();
        pipe_flush = 1'b0;
        chk("flush valid", 32'(skip_valid), 32'd0);
        chk("flush busy", 32'(busy), 32'd0);
        chk_counts("flush");

        // drive the narrow instance's skip counter past all-ones
        for (int i = 0; i < 12; i++) apply_vec(vecs[0], $sformatf("sat%0d", i));

        // async reset while a redirect is pending
        skip_ready = 1'b0;
        hit(5'd5, 5'd6, SASA_COND_OR, 5'd3, 32'h100);
        step();
        chk("rsk valid pre", 32'(skip_valid), 32'd1);
        #2 nRST = 1'b0;
        #1;
        sc = 0; ac = 0;
        chk("rsk valid", 32'(skip_valid), 32'd0);
        chk("rsk target", skip_target, 32'd0);
        chk("rsk busy", 32'(busy), 32'd0);
        chk_counts("rsk");
        #1 nRST = 1'b1;
        skip_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post-rst valid c%0d", k), 32'(skip_valid), 32'd0);
            chk($sformatf("post-rst busy c%0d", k), 32'(busy), 32'd0);
        end
        chk_counts("post-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
